cycle_sequencer: RTL and testbench
==================================

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-low. Ports are named i_Clk and i_Rst_n.
REQ-002 i_Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 i_Rst_n  input  1  synchronous active-low reset.
REQ-004 i_Wait  input  1  stall; while high, all state is frozen.
REQ-005 i_IR_Fetch  input  1  OR of all microcode o_IR_Fetch; high means the current M-cycle is the last of the instruction.
REQ-006 i_Data  input  8  data bus; carries the fetched opcode during T-step 3.
REQ-007 o_Cycle_Step  output  4  one-hot T-step within the M-cycle.
REQ-008 o_Cycle_Count  output  8  one-hot M-cycle index within the instruction.
REQ-009 o_IR  output  8  current instruction register.
REQ-010 o_P  output  4  one-hot decode of o_IR[5:4].
REQ-011 o_Q  output  2  one-hot decode of o_IR[3]: bit0 when IR[3]=0, bit1 when IR[3]=1.
REQ-012 o_M_End  output  1  combinational; high when o_Cycle_Step[3] is high and i_Wait is low.
REQ-013 o_Instr_Start  output  1  registered; one-clock pulse on the first T-step of a new instruction.
REQ-014 o_Overrun  output  1  sticky error flag.

Function
REQ-015 o_Cycle_Step SHALL rotate left once per clock with i_Wait low: 0001, 0010, 0100, 1000, then back to 0001.
REQ-016 At a step 1000 to 0001 transition with i_IR_Fetch high:
  - o_Cycle_Count SHALL load 0000_0001;
  - o_IR SHALL load i_Data;
  - o_P and o_Q SHALL update in the same clock, with no extra latency.
REQ-017 At a step 1000 to 0001 transition with i_IR_Fetch low, o_Cycle_Count SHALL shift left by one; o_IR, o_P and o_Q SHALL hold.
REQ-018 At a step wrap with i_IR_Fetch low and o_Cycle_Count = 1000_0000:
  - o_Cycle_Count SHALL hold at 1000_0000 and never become zero;
  - o_Overrun SHALL set and stay set until reset.
REQ-019 i_IR_Fetch SHALL be sampled only at the step wrap; its value on T-steps 0 to 2 has no effect.
REQ-020 While i_Wait is high:
  - step, count, IR, P, Q, o_Instr_Start and o_Overrun SHALL all hold;
  - o_M_End SHALL be low.
REQ-021 If i_Wait rises on step 1000, the wrap and the IR load SHALL be deferred until the first clock with i_Wait low. i_Data and i_IR_Fetch SHALL be sampled on that clock.
REQ-022 o_Instr_Start SHALL be high for exactly the one clock in which o_Cycle_Step = 0001 and o_Cycle_Count = 0000_0001 follow an IR load. It is low otherwise, including out of reset.
REQ-023 o_Cycle_Step and o_Cycle_Count SHALL be exactly one-hot in every cycle after reset.
REQ-024 The o_P mapping SHALL be: IR[5:4] = 00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000.

Reset
REQ-025 With i_Rst_n low at a rising edge, the outputs SHALL take these values:
  - o_Cycle_Step = 0001;
  - o_Cycle_Count = 0000_0001;
  - o_IR = 0x00 (NOP), so o_P = 0001 and o_Q = 01;
  - o_Instr_Start = 0;
  - o_Overrun = 0.
REQ-026 Reset SHALL take priority over i_Wait and i_IR_Fetch, and SHALL abort an instruction in progress on any step.
REQ-027 The first M-cycle after reset SHALL execute as NOP count 0, whose microcode asserts i_IR_Fetch to fetch the first real opcode.

Structure
REQ-028 The shared package/include SHALL hold these constants:
  - STEP_RESET (4'b0001);
  - COUNT_RESET (8'b0000_0001);
  - NOP_OPCODE (8'h00);
  - the widths 4 (step), 8 (count) and 8 (IR).
REQ-029 The block SHALL use one sub-module, onehot_ring, parameterised by width. It has load, shift, hold and saturate controls and is instantiated twice: step (width 4) and count (width 8).
REQ-030 IR, P and Q SHALL be registers in the top level. P and Q SHALL be decoded from the next-IR value, not from o_IR, to meet REQ-016.

Verification
REQ-031 Reset, then 4 clocks with i_Wait=0 and i_IR_Fetch=1, i_Data=0x12 ->
  - step 0001, 0010, 0100, 1000, then 0001;
  - IR=0x12, P=0010, Q=01, count=0000_0001;
  - o_Instr_Start pulses once.
REQ-032 IR=0x22, i_IR_Fetch=0 for 8 clocks, then 1 with i_Data=0x0A ->
  - count goes 01 to 02 to 04, then reloads 01 at the third wrap;
  - IR=0x0A, P=0001, Q=10.
REQ-033 i_IR_Fetch held at 0 for 40 clocks ->
  - count reaches 1000_0000 at clock 28 and holds;
  - o_Overrun=1 from clock 32 onward.
REQ-034 i_Wait=1 for 5 clocks on step 1000, with i_Data changing ->
  - no state change and o_M_End=0 throughout;
  - on release, IR loads the i_Data present on the release clock.
REQ-035 i_Rst_n=0 asserted on step 0100 with count 0000_0100 and o_Overrun=1 -> next edge: step 0001, count 0000_0001, IR=0x00, o_Overrun=0.
REQ-036 Every scenario SHALL check, on every clock, that o_Cycle_Step and o_Cycle_Count are one-hot.

Source files
------------

// File: rtl/cycle_sequencer_pkg.sv
// Shared constants and decode helpers for the M-cycle / T-step sequencer.
package cycle_sequencer_pkg;

  localparam int unsigned STEP_W  = 4;
  localparam int unsigned COUNT_W = 8;
  localparam int unsigned IR_W    = 8;

  localparam logic [STEP_W-1:0]  STEP_RESET  = 4'b0001;
  localparam logic [COUNT_W-1:0] COUNT_RESET = 8'b0000_0001;
  localparam logic [IR_W-1:0]    NOP_OPCODE  = 8'h00;

  // One-hot decode of opcode bits [5:4].
  function automatic logic [3:0] decode_p(input logic [IR_W-1:0] ir);
    decode_p = 4'b0001 << ir[5:4];
  endfunction

  // One-hot decode of opcode bit 3.
  function automatic logic [1:0] decode_q(input logic [IR_W-1:0] ir);
    decode_q = ir[3] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/onehot_ring.sv
// One-hot ring register with hold, load, rotate-left and saturate-at-MSB controls.
module onehot_ring #(
  parameter int unsigned      Width    = 4,
  parameter logic [Width-1:0] ResetVal = Width'(1),
  parameter logic [Width-1:0] LoadVal  = Width'(1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             saturate_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] ring_d, ring_q;

  // Next-state: hold beats load beats shift; saturation stops the MSB from wrapping.
  always_comb begin
    ring_d = ring_q;
    if (hold_i) begin
      ring_d = ring_q;
    end else if (load_i) begin
      ring_d = LoadVal;
    end else if (shift_i) begin
      if (saturate_i && ring_q[Width-1]) begin
        ring_d = ring_q;
      end else begin
        ring_d = {ring_q[Width-2:0], ring_q[Width-1]};
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ring_q <= ResetVal;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign q_o = ring_q;

endmodule

// File: rtl/cycle_sequencer.sv
// T-step / M-cycle sequencer with instruction register and P/Q opcode decode.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Wait,
  input  logic               i_IR_Fetch,
  input  logic [IR_W-1:0]    i_Data,
  output logic [STEP_W-1:0]  o_Cycle_Step,
  output logic [COUNT_W-1:0] o_Cycle_Count,
  output logic [IR_W-1:0]    o_IR,
  output logic [3:0]         o_P,
  output logic [1:0]         o_Q,
  output logic               o_M_End,
  output logic               o_Instr_Start,
  output logic               o_Overrun
);

  logic [STEP_W-1:0]  step_q;
  logic [COUNT_W-1:0] count_q;
  logic [IR_W-1:0]    ir_d, ir_q;
  logic [3:0]         p_q;
  logic [1:0]         q_q;
  logic               start_d, start_q;
  logic               overrun_d, overrun_q;
  logic               wrap;
  logic               fetch_wrap;

  // A wrap only happens on the last T-step of a non-stalled clock.
  assign wrap       = step_q[STEP_W-1] & ~i_Wait;
  assign fetch_wrap = wrap & i_IR_Fetch;

  onehot_ring #(
    .Width    (STEP_W),
    .ResetVal (STEP_RESET),
    .LoadVal  (STEP_RESET)
  ) u_step_ring (
    .clk_i      (i_Clk),
    .rst_ni     (i_Rst_n),
    .hold_i     (i_Wait),
    .load_i     (1'b0),
    .shift_i    (1'b1),
    .saturate_i (1'b0),
    .q_o        (step_q)
  );

  onehot_ring #(
    .Width    (COUNT_W),
    .ResetVal (COUNT_RESET),
    .LoadVal  (COUNT_RESET)
  ) u_count_ring (
    .clk_i      (i_Clk),
    .rst_ni     (i_Rst_n),
    .hold_i     (i_Wait),
    .load_i     (fetch_wrap),
    .shift_i    (wrap & ~i_IR_Fetch),
    .saturate_i (1'b1),
    .q_o        (count_q)
  );

  // Next IR, start pulse and sticky overrun; stall freezes everything.
  always_comb begin
    ir_d      = ir_q;
    start_d   = start_q;
    overrun_d = overrun_q;
    if (!i_Wait) begin
      start_d = fetch_wrap;
      if (fetch_wrap) begin
        ir_d = i_Data;
      end
      if (wrap && !i_IR_Fetch && count_q[COUNT_W-1]) begin
        overrun_d = 1'b1;
      end
    end
  end

  // P/Q decode from next-IR so they change on the same edge as the IR.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      ir_q      <= NOP_OPCODE;
      p_q       <= decode_p(NOP_OPCODE);
      q_q       <= decode_q(NOP_OPCODE);
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      p_q       <= decode_p(ir_d);
      q_q       <= decode_q(ir_d);
      start_q   <= start_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_Cycle_Step  = step_q;
  assign o_Cycle_Count = count_q;
  assign o_IR          = ir_q;
  assign o_P           = p_q;
  assign o_Q           = q_q;
  assign o_M_End       = step_q[STEP_W-1] & ~i_Wait;
  assign o_Instr_Start = start_q;
  assign o_Overrun     = overrun_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer against a step/M-cycle index model.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wt = 1'b0;
  logic       fe = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] step;
  logic [7:0] count;
  logic [7:0] ir;
  logic [3:0] p;
  logic [1:0] q;
  logic       m_end;
  logic       start;
  logic       ovr;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Reference model: T-step index 0..3, M-cycle index 0..7.
  int         m_idx = 0;
  int         m_mc = 0;
  logic [7:0] m_ir = 8'h00;
  bit         m_ov = 1'b0;
  bit         m_start = 1'b0;

  cycle_sequencer dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Wait        (wt),
    .i_IR_Fetch    (fe),
    .i_Data        (data),
    .o_Cycle_Step  (step),
    .o_Cycle_Count (count),
    .o_IR          (ir),
    .o_P           (p),
    .o_Q           (q),
    .o_M_End       (m_end),
    .o_Instr_Start (start),
    .o_Overrun     (ovr)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    if (!rst_n) begin
      m_idx = 0; m_mc = 0; m_ir = 8'h00; m_ov = 1'b0; m_start = 1'b0;
    end else if (!wt) begin
      m_start = (m_idx == 3) && fe;
      if (m_idx == 3) begin
        if (fe) begin
          m_mc = 0;
          m_ir = data;
        end else if (m_mc == 7) begin
          m_ov = 1'b1;
        end else begin
          m_mc = m_mc + 1;
        end
      end
      m_idx = (m_idx + 1) % 4;
    end
  endtask

  // Drive one clock; returns 1 time unit after the rising edge.
  task automatic tick(input logic r, input logic w, input logic f, input logic [7:0] d);
    rst_n = r; wt = w; fe = f; data = d;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Every-clock comparison against the model plus one-hot checks.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] e_step;
      logic [7:0] e_count;
      logic [3:0] e_p;
      logic [1:0] e_q;
      logic       e_mend;
      e_step  = 4'd1 << m_idx;
      e_count = 8'd1 << m_mc;
      e_p     = 4'd1 << m_ir[5:4];
      e_q     = m_ir[3] ? 2'b10 : 2'b01;
      e_mend  = (m_idx == 3) && !wt;
      checks++;
      if ({step, count, ir, p, q, start, ovr, m_end} !==
          {e_step, e_count, m_ir, e_p, e_q, m_start, m_ov, e_mend}) begin
        errors++;
        $display("FAIL model t=%0t step=%b/%b count=%b/%b ir=%h/%h p=%b/%b q=%b/%b st=%b/%b ov=%b/%b me=%b/%b",
                 $time, step, e_step, count, e_count, ir, m_ir, p, e_p, q, e_q,
                 start, m_start, ovr, m_ov, m_end, e_mend);
      end
      checks++;
      if (!$onehot(step) || !$onehot(count)) begin
        errors++;
        $display("FAIL onehot t=%0t step=%b count=%b required one-hot", $time, step, count);
      end
    end
  end

  task automatic test_reset();
    tick(1'b0, 1'b1, 1'b1, 8'hFF);
    tick(1'b0, 1'b0, 1'b1, 8'hFF);
    mon_en = 1'b1;
    checks++;
    if ({step, count, ir, p, q, start, ovr} !== {4'b0001, 8'h01, 8'h00, 4'b0001, 2'b01, 2'b00})
    begin
      errors++;
      $display("FAIL reset_state step=%b count=%b ir=%h p=%b q=%b st=%b ov=%b required 0001 01 00 0001 01 0 0",
               step, count, ir, p, q, start, ovr);
    end
  endtask

  task automatic test_first_fetch();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, 8'h12);
      if (start === 1'b1) pulses++;
    end
    checks++;
    if ({step, ir, p, q, count} !== {4'b0001, 8'h12, 4'b0010, 2'b01, 8'h01}) begin
      errors++;
      $display("FAIL first_fetch step=%b ir=%h p=%b q=%b count=%b required 0001 12 0010 01 01",
               step, ir, p, q, count);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL first_fetch_pulse got %0d pulses required 1", pulses);
    end
  endtask

  task automatic test_multi_cycle();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'h55);
    tick(1'b1, 1'b0, 1'b1, 8'h22);
    checks++;
    if (ir !== 8'h22) begin
      errors++;
      $display("FAIL load_22 ir=%h required 22", ir);
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'h99);
      if (i == 4 || i == 8) begin
        checks++;
        if (count !== ((i == 4) ? 8'h02 : 8'h04)) begin
          errors++;
          $display("FAIL count_shift clk=%0d count=%b required %b", i, count,
                   (i == 4) ? 8'h02 : 8'h04);
        end
      end
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 8'hEE);
    checks++;
    if (count !== 8'h04 || ir !== 8'h22) begin
      errors++;
      $display("FAIL fetch_midstep count=%b ir=%h required 00000100 22", count, ir);
    end
    tick(1'b1, 1'b0, 1'b1, 8'h0A);
    checks++;
    if ({count, ir, p, q} !== {8'h01, 8'h0A, 4'b0001, 2'b10}) begin
      errors++;
      $display("FAIL reload_0a count=%b ir=%h p=%b q=%b required 01 0a 0001 10", count, ir, p, q);
    end
  endtask

  task automatic test_overrun();
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'($urandom));
      if (i == 27 || i == 28 || i == 40) begin
        checks++;
        if (count !== ((i == 27) ? 8'h40 : 8'h80)) begin
          errors++;
          $display("FAIL count_sat clk=%0d count=%b", i, count);
        end
      end
      if (i == 31 || i == 32 || i == 40) begin
        checks++;
        if (ovr !== (i != 31)) begin
          errors++;
          $display("FAIL overrun clk=%0d ov=%b required %b", i, ovr, i != 31);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b1, 8'hC7);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({step, count, ovr} !== {4'b0100, 8'h04, 1'b1}) begin
      errors++;
      $display("FAIL abort_setup step=%b count=%b ov=%b required 0100 00000100 1", step, count, ovr);
    end
    tick(1'b0, 1'b1, 1'b1, 8'h3C);
    checks++;
    if ({step, count, ir, ovr, start} !== {4'b0001, 8'h01, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_abort step=%b count=%b ir=%h ov=%b st=%b required 0001 01 00 0 0",
               step, count, ir, ovr, start);
    end
  endtask

  task automatic test_wait();
    logic [7:0] d;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 8'h33);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'($urandom), 8'($urandom));
      checks++;
      if ({step, count, ir, m_end} !== {4'b1000, 8'h01, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL wait_hold i=%0d step=%b count=%b ir=%h me=%b required 1000 01 00 0",
                 i, step, count, ir, m_end);
      end
    end
    d = 8'($urandom) | 8'h01;
    tick(1'b1, 1'b0, 1'b1, d);
    checks++;
    if ({step, ir, start} !== {4'b0001, d, 1'b1}) begin
      errors++;
      $display("FAIL wait_release step=%b ir=%h st=%b required 0001 %h 1", step, ir, start, d);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick(1'(($urandom % 60) != 0), 1'(($urandom % 4) == 0), 1'(($urandom % 3) == 0),
           8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_multi_cycle();
    test_overrun();
    test_reset_abort();
    test_wait();
    test_random();
    #10;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
